// File: rtl/rojo_pkg.sv
// Shared types and constants for the RojoBot update handshake.
//   rojo_hs_state_t : handshake FSM state encoding
//   ROJO_REG_W      : default width of one RojoBot register
package rojo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } rojo_hs_state_t;

  localparam int ROJO_REG_W = 8;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop level synchronizer for one asynchronous bit.
//   clk : destination clock
//   rst : synchronous, active-high; clears every stage
//   d   : asynchronous input level
//   q   : synchronized level (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rojo_upd_handshake.sv
// Snapshots the RojoBot registers on each upd_sysregs rising edge and holds an
// interrupt level for the core until it acknowledges through i_int_ack.
// Counts captured updates (wrapping) and updates lost before service (saturating).
//   clk, rst                    : clk_rojo, synchronous active-high reset
//   i_upd                       : upd_sysregs level
//   i_locx/locy/sensors/botinfo : live RojoBot registers
//   i_int_ack                   : asynchronous acknowledge level from the core
//   o_locx/locy/sensors/botinfo : stable snapshot
//   o_botupdt                   : update pending interrupt level
//   o_upd_cnt, o_ovr_cnt        : update and overrun counters
//
// state | meaning
// IDLE  | nothing pending
// PEND  | snapshot valid, interrupt asserted, waiting for ack to rise
// HOLD  | ack seen, interrupt dropped, waiting for ack to fall
module rojo_upd_handshake
  import rojo_pkg::*;
#(
  parameter int REG_W       = ROJO_REG_W,
  parameter int SYNC_STAGES = 2,
  parameter int UPD_CNT_W   = 16,
  parameter int OVR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_upd,
  input  logic [REG_W-1:0]     i_locx,
  input  logic [REG_W-1:0]     i_locy,
  input  logic [REG_W-1:0]     i_sensors,
  input  logic [REG_W-1:0]     i_botinfo,
  input  logic                 i_int_ack,
  output logic [REG_W-1:0]     o_locx,
  output logic [REG_W-1:0]     o_locy,
  output logic [REG_W-1:0]     o_sensors,
  output logic [REG_W-1:0]     o_botinfo,
  output logic                 o_botupdt,
  output logic [UPD_CNT_W-1:0] o_upd_cnt,
  output logic [OVR_CNT_W-1:0] o_ovr_cnt
);

  rojo_hs_state_t state, state_n;
  logic defer, defer_n;
  logic ovr_inc;
  logic upd_q, ack_s, ack_q;
  logic upd_rise, ack_rise, ack_fall;

  sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_int_ack),
    .q   (ack_s)
  );

  assign upd_rise = i_upd & ~upd_q;
  assign ack_rise = ack_s & ~ack_q;
  assign ack_fall = ~ack_s & ack_q;

  always_comb begin
    state_n = state;
    defer_n = defer;
    ovr_inc = 1'b0;
    case (state)
      IDLE: begin
        if (upd_rise) state_n = PEND;
      end
      PEND: begin
        if (ack_rise) begin
          // An update racing the ack is still unseen by the core, so it is
          // deferred rather than counted as lost.
          state_n = HOLD;
          defer_n = upd_rise;
        end else if (upd_rise) begin
          ovr_inc = 1'b1;
        end
      end
      HOLD: begin
        if (upd_rise && defer) ovr_inc = 1'b1;
        if (ack_fall) begin
          state_n = (defer || upd_rise) ? PEND : IDLE;
          defer_n = 1'b0;
        end else if (upd_rise) begin
          defer_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        defer_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      defer     <= 1'b0;
      upd_q     <= 1'b0;
      ack_q     <= 1'b0;
      o_upd_cnt <= '0;
      o_ovr_cnt <= '0;
    end else begin
      state <= state_n;
      defer <= defer_n;
      upd_q <= i_upd;
      ack_q <= ack_s;
      if (upd_rise) o_upd_cnt <= o_upd_cnt + 1'b1;
      if (ovr_inc && (o_ovr_cnt != '1)) o_ovr_cnt <= o_ovr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_locx    <= '0;
      o_locy    <= '0;
      o_sensors <= '0;
      o_botinfo <= '0;
    end else if (upd_rise) begin
      o_locx    <= i_locx;
      o_locy    <= i_locy;
      o_sensors <= i_sensors;
      o_botinfo <= i_botinfo;
    end
  end

  assign o_botupdt = (state == PEND);

endmodule
